// File: rtl/derivative_peak_detector.sv
// Hysteresis trend classifier for a signed derivative stream: flags peaks and valleys with
// minimum event spacing and a wrapping peak counter. Define VALLEY_DETECT_EN to emit valleys.
module derivative_peak_detector #(
    parameter int Nbits   = 8,
    parameter int THRESH  = 2,
    parameter int MIN_GAP = 3,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [Nbits-1:0] in_der,
    input  logic                    in_valid,
    input  logic                    count_clr,
    output logic                    peak_pulse,
    output logic                    valley_pulse,
    output logic [1:0]              trend,
    output logic [CNT_W-1:0]        peak_count,
    output logic                    cnt_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10
    } state_t;

    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

`ifdef VALLEY_DETECT_EN
    localparam bit VALLEY_EN = 1'b1;
`else
    localparam bit VALLEY_EN = 1'b0;
`endif

    state_t                 state, state_nxt;
    logic [GAP_W-1:0]       gap_cnt;
    logic signed [Nbits:0]  der_ext, thr_pos, thr_neg;
    logic                   is_pos, is_neg;
    logic                   peak_evt, valley_evt;
    logic                   gap_open, peak_emit, valley_emit;

    // One extra bit so that -THRESH and the most negative sample compare without overflow.
    assign der_ext = {in_der[Nbits-1], in_der};
    assign thr_pos = (Nbits + 1)'(THRESH);
    assign thr_neg = -thr_pos;
    assign is_pos  = der_ext > thr_pos;
    assign is_neg  = der_ext < thr_neg;

    assign gap_open    = (gap_cnt == '0);
    assign peak_emit   = peak_evt & gap_open;
    assign valley_emit = valley_evt & gap_open & VALLEY_EN;
    assign trend       = state;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt  = state;
        peak_evt   = 1'b0;
        valley_evt = 1'b0;
        if (in_valid) begin
            unique case (state)
                IDLE: begin
                    if (is_pos)      state_nxt = RISE;
                    else if (is_neg) state_nxt = FALL;
                end
                RISE: begin
                    if (is_neg) begin
                        state_nxt = FALL;
                        peak_evt  = 1'b1;
                    end
                end
                FALL: begin
                    if (is_pos) begin
                        state_nxt  = RISE;
                        valley_evt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            peak_pulse   <= 1'b0;
            valley_pulse <= 1'b0;
            peak_count   <= '0;
            cnt_ovf      <= 1'b0;
        end else begin
            peak_pulse   <= peak_emit;
            valley_pulse <= valley_emit;

            if (in_valid) begin
                state <= state_nxt;
                if (peak_emit || valley_emit) gap_cnt <= GAP_W'(MIN_GAP);
                else if (!gap_open)           gap_cnt <= gap_cnt - 1'b1;
            end

            // A clear coinciding with a peak counts that peak into the freshly cleared counter.
            if (peak_emit) begin
                if (count_clr) begin
                    peak_count <= CNT_W'(1);
                    cnt_ovf    <= 1'b0;
                end else if (peak_count == '1) begin
                    peak_count <= '0;
                    cnt_ovf    <= 1'b1;
                end else begin
                    peak_count <= peak_count + 1'b1;
                end
            end else if (count_clr) begin
                peak_count <= '0;
                cnt_ovf    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_derivative_peak_detector.sv
// Self-checking bench for derivative_peak_detector: directed scenarios plus random stimulus
// compared against a trend/gap/counter reference model.
module tb_derivative_peak_detector;

    localparam int NB = 8;
    localparam int TH = 2;
    localparam int MG = 3;
    localparam int CW = 8;

`ifdef VALLEY_DETECT_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [NB-1:0] in_der;
    logic                 in_valid;
    logic                 count_clr;
    logic                 peak_pulse;
    logic                 valley_pulse;
    logic [1:0]           trend;
    logic [CW-1:0]        peak_count;
    logic                 cnt_ovf;
    logic [12:0]          act_vec;

    int checks   = 0;
    int failures = 0;

    // Reference model: trend follows the last non-flat class; events are class reversals.
    int m_trend;  // 0 idle, 1 rise, 2 fall
    int m_gap;
    int m_cnt;
    bit m_ovf, m_peak, m_valley;

    derivative_peak_detector #(
        .Nbits(NB), .THRESH(TH), .MIN_GAP(MG), .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_der      (in_der),
        .in_valid    (in_valid),
        .count_clr   (count_clr),
        .peak_pulse  (peak_pulse),
        .valley_pulse(valley_pulse),
        .trend       (trend),
        .peak_count  (peak_count),
        .cnt_ovf     (cnt_ovf)
    );

    always #5 clk = ~clk;

    assign act_vec = {peak_pulse, valley_pulse, trend, peak_count, cnt_ovf};

    function automatic logic [12:0] exp_vec();
        logic [1:0] t;
        logic [7:0] c;
        t = 2'(m_trend);
        c = 8'(m_cnt);
        return {m_peak, m_valley, t, c, m_ovf};
    endfunction

    task automatic model_reset();
        m_trend = 0; m_gap = 0; m_cnt = 0;
        m_ovf = 0; m_peak = 0; m_valley = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit clr);
        int cls;
        bit peak_ev, valley_ev;
        m_peak   = 0;
        m_valley = 0;
        if (v) begin
            cls       = (d > TH) ? 1 : ((d < -TH) ? -1 : 0);
            peak_ev   = (m_trend == 1) && (cls == -1);
            valley_ev = (m_trend == 2) && (cls == 1);
            if (cls == 1)  m_trend = 1;
            if (cls == -1) m_trend = 2;
            m_peak   = peak_ev && (m_gap == 0);
            m_valley = valley_ev && (m_gap == 0) && VEN;
            if (m_peak || m_valley) m_gap = MG;
            else if (m_gap > 0)     m_gap = m_gap - 1;
        end
        if (m_peak) begin
            if (clr) begin
                m_cnt = 1; m_ovf = 0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == (1 << CW)) begin
                    m_cnt = 0; m_ovf = 1;
                end
            end
        end else if (clr) begin
            m_cnt = 0; m_ovf = 0;
        end
    endtask

    task automatic apply(input bit v, input int d, input bit clr);
        @(negedge clk);
        in_valid  = v;
        in_der    = d[NB-1:0];
        count_clr = clr;
        model_step(v, d, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_der = '0; count_clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_der = '0; count_clr = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act_vec !== 13'd0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", act_vec, 13'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int seq [4] = '{5, 5, -5, 0};
        bit vld [4] = '{1, 1, 1, 0};
        do_reset();
        foreach (seq[i]) begin
            apply(vld[i], seq[i], 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL basic step %0d: got %h expected %h", i, act_vec, exp_vec());
            end
            if (i == 2) begin
                checks++;
                if (peak_pulse !== 1'b1 || peak_count !== 8'd1) begin
                    failures++;
                    $display("FAIL basic_peak: got pulse=%b count=%0d expected pulse=1 count=1",
                             peak_pulse, peak_count);
                end
            end
        end
    endtask

    task automatic test_flat();
        int seq [5] = '{5, 2, -2, 1, -3};
        do_reset();
        foreach (seq[i]) begin
            apply(1'b1, seq[i], 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL flat step %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_threshold();
        int seq [8] = '{3, -3, 127, -128, 2, -2, 3, -3};
        do_reset();
        foreach (seq[i]) begin
            apply(1'b1, seq[i], 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL threshold step %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int seq [4] = '{5, -5, 5, -5};
        do_reset();
        foreach (seq[i]) begin
            apply(1'b1, seq[i], 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL back_to_back step %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        checks++;
        if (trend !== 2'b10 || peak_count !== 8'd1) begin
            failures++;
            $display("FAIL back_to_back_end: got trend=%b count=%0d expected trend=10 count=1",
                     trend, peak_count);
        end
    endtask

    task automatic test_invalid_hold();
        do_reset();
        apply(1'b1, 5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, -100, 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL invalid_hold cycle %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        apply(1'b1, -5, 1'b0);
        checks++;
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL invalid_hold_peak: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    // One spaced peak: rise, drain the gap, fall, drain the gap again.
    task automatic peak_cycle(input string name, input bit clr_on_peak);
        int seq [8] = '{5, 0, 0, 0, -5, 0, 0, 0};
        foreach (seq[i]) begin
            apply(1'b1, seq[i], (i == 4) ? clr_on_peak : 1'b0);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL %s step %0d: got %h expected %h", name, i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 255; k++) peak_cycle("preload", 1'b0);
        checks++;
        if (peak_count !== 8'd255 || cnt_ovf !== 1'b0) begin
            failures++;
            $display("FAIL preload_count: got count=%0d ovf=%b expected count=255 ovf=0",
                     peak_count, cnt_ovf);
        end
        peak_cycle("wrap", 1'b0);
        checks++;
        if (peak_count !== 8'd0 || cnt_ovf !== 1'b1) begin
            failures++;
            $display("FAIL wrap: got count=%0d ovf=%b expected count=0 ovf=1", peak_count, cnt_ovf);
        end
        peak_cycle("clr_with_peak", 1'b1);
        checks++;
        if (peak_count !== 8'd1 || cnt_ovf !== 1'b0) begin
            failures++;
            $display("FAIL clr_with_peak_end: got count=%0d ovf=%b expected count=1 ovf=0",
                     peak_count, cnt_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int seq [3] = '{5, -5, 5};
        do_reset();
        foreach (seq[i]) apply(1'b1, seq[i], 1'b0);
        checks++;
        if (act_vec !== exp_vec()) begin
            failures++;
            $display("FAIL pre_reset: got %h expected %h", act_vec, exp_vec());
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act_vec !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", act_vec, 13'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 5, 1'b0);
        apply(1'b1, -5, 1'b0);
        checks++;
        if (act_vec !== exp_vec() || peak_pulse !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_peak: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        int d;
        bit v, clr;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 255)) - 128;
            else                          d = int'($urandom_range(0, 12)) - 6;
            apply(v, d, clr);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random step %0d (v=%0b d=%0d clr=%0b): got %h expected %h",
                         i, v, d, clr, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_der = '0; count_clr = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_flat();
        test_threshold();
        test_back_to_back();
        test_invalid_hold();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
